bf_fetch_unit: RTL
==================

Name: bf_fetch_unit

Overview:
Instruction fetch stage of the brainfuck CPU. It sits directly upstream of the instruction memory block and drives its i_req/i_addr/i_ack/i_rdata interface. Fetched opcode bytes go into a small prefetch FIFO, and the decode/execute stage consumes them through a valid/ready handshake. Loop control redirects fetch through a jump port, which flushes the prefetched bytes.

Parameters:
i_addr_width, 16, width of instruction address / PC
i_mem_length, 1024, number of valid instruction bytes; addresses >= this are past end of program
fifo_depth, 4, prefetch FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_req  output  1  fetch request to instruction memory
i_addr  output  i_addr_width  fetch address, stable while i_req high
i_ack  input  1  memory acknowledge; i_rdata valid in the same cycle
i_rdata  input  8  fetched opcode byte
inst_valid  output  1  FIFO head valid
inst_data  output  8  FIFO head opcode
inst_addr  output  i_addr_width  address of FIFO head opcode
inst_ready  input  1  consumer pops head when inst_valid & inst_ready
jump_valid  input  1  redirect request (one-cycle pulse)
jump_addr  input  i_addr_width  redirect target
prog_end  output  1  fetch PC >= i_mem_length, FIFO empty, no fetch in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: pc=0, FIFO empty, i_req=0, i_addr=0, inst_valid=0, inst_data=0, inst_addr=0, prog_end=0, state=GAP.
- Memory protocol:
  - The memory acks in the cycle after it samples i_req high, and its ack path stays armed while i_req is held.
  - Every transaction is therefore: assert i_req with a fixed i_addr, hold both until i_ack=1, then capture i_rdata on that edge.
  - i_req must go low for at least one full cycle (GAP) before the next request.
  - Minimum 3 cycles per byte.
- FSM:
  - GAP: i_req=0. Go to REQ when pc < i_mem_length and (fifo_count + 0) < fifo_depth. Otherwise stay in GAP.
  - REQ: i_req=1, i_addr=pc. On i_ack: push {pc, i_rdata}, pc<=pc+1, go to GAP.
  - One fetch in flight at most. A fetch is issued only when the FIFO has a free slot at issue time; pops cannot reduce free space, so the push always fits.
- FIFO:
  - Push and pop in the same cycle are both performed and count is unchanged.
  - Pop on an empty FIFO is impossible, because inst_valid=0.
  - inst_data/inst_addr are the head entry; their value when inst_valid=0 is don't-care.
  - Read/write pointers wrap modulo fifo_depth.
- Jump, highest priority:
  - When jump_valid=1, on that edge the FIFO is cleared (a simultaneous pop is discarded, not counted) and pc<=jump_addr. Any push from a simultaneous i_ack is dropped.
  - The state is forced to GAP. If REQ was active without ack, the fetch is abandoned and i_req drops the next cycle.
  - The earliest request to jump_addr is two cycles after the jump edge (one GAP cycle).
  - A jump while already in GAP behaves the same way.
- End of program:
  - Fetching stops when pc >= i_mem_length.
  - prog_end is registered: high once pc >= i_mem_length and the FIFO is empty and state=GAP.
  - A jump to an in-range address clears prog_end on the next edge.
  - A jump_addr >= i_mem_length sets prog_end after the flush.
- PC arithmetic is i_addr_width wide, with no wrap past i_mem_length, because fetch halts first.
- Reset asserted mid-transaction: all state returns to reset values immediately and i_req drops asynchronously.

Test Plan:
- Straight-line fetch: memory holds bytes 0x2B,0x3E,0x2D at 0..2, inst_ready=1 → inst_valid pulses with inst_data 0x2B/0x3E/0x2D and inst_addr 0/1/2. i_req shows a 1,1,0 pattern, one byte per 3 cycles.
- Backpressure: inst_ready=0, fifo_depth=4 → exactly 4 fetches (addr 0..3), then i_req stays 0. Raising inst_ready drains 4 entries in order, and fetch resumes at addr 4.
- Jump during REQ: assert jump_valid with jump_addr=0x0010 in the cycle i_req=1 and i_ack=0 → i_req is 0 the next cycle, the FIFO is empty (inst_valid=0), and the next i_req has i_addr=0x0010 two cycles after the jump. The first popped inst_addr is 0x0010.
- Jump coincident with i_ack and pop → the acked byte is never presented, and the FIFO is empty after the edge.
- End of program with i_mem_length=3 → after 3 bytes are consumed, prog_end=1 and i_req stays 0. A jump to 0 then clears prog_end, and fetch restarts at addr 0.
- Async reset: pull rst_n low mid-REQ between clock edges → i_req, inst_valid and prog_end are 0 immediately. After release, the first fetch is at i_addr=0.

Source files
------------

// File: rtl/bf_fetch_unit.sv
// Brainfuck CPU instruction fetch stage: single-outstanding memory fetch
// feeding a small prefetch FIFO, with jump redirect and end-of-program detect.
module bf_fetch_unit #(
    parameter int i_addr_width = 16,
    parameter int i_mem_length = 1024,
    parameter int fifo_depth   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    i_req,
    output logic [i_addr_width-1:0] i_addr,
    input  logic                    i_ack,
    input  logic [7:0]              i_rdata,
    output logic                    inst_valid,
    output logic [7:0]              inst_data,
    output logic [i_addr_width-1:0] inst_addr,
    input  logic                    inst_ready,
    input  logic                    jump_valid,
    input  logic [i_addr_width-1:0] jump_addr,
    output logic                    prog_end
);

    localparam int pw = $clog2(fifo_depth);
    localparam int cw = pw + 1;
    localparam logic [i_addr_width:0] end_addr = (i_addr_width + 1)'(i_mem_length);
    localparam logic [cw-1:0] depth = cw'(fifo_depth);

    typedef enum logic {
        GAP = 1'b0,
        REQ = 1'b1
    } state_t;

    state_t state;
    state_t state_n;

    logic [i_addr_width-1:0] pc;
    logic [i_addr_width-1:0] pc_n;
    logic [7:0]              fifo_data [fifo_depth];
    logic [i_addr_width-1:0] fifo_addr [fifo_depth];
    logic [pw-1:0]           rd_ptr;
    logic [pw-1:0]           wr_ptr;
    logic [cw-1:0]           count;
    logic [cw-1:0]           count_n;
    logic                    push;
    logic                    pop;
    logic                    pc_in_range;
    logic                    pc_n_in_range;
    logic                    prog_end_n;

    // A jump overrides both a same-cycle ack and a same-cycle pop.
    assign push = (state == REQ) && i_ack && !jump_valid;
    assign pop  = inst_valid && inst_ready && !jump_valid;

    assign pc_in_range   = {1'b0, pc} < end_addr;
    assign pc_n_in_range = {1'b0, pc_n} < end_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GAP;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            GAP: begin
                if (pc_in_range && (count < depth)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (i_ack) begin
                    state_n = GAP;
                end
            end
        endcase
        if (jump_valid) begin
            state_n = GAP;
        end
    end

    always_comb begin
        i_req  = (state == REQ);
        i_addr = pc;
    end

    always_comb begin
        pc_n    = pc;
        count_n = count;
        if (jump_valid) begin
            pc_n    = jump_addr;
            count_n = '0;
        end else begin
            if (push) begin
                pc_n = pc + 1'b1;
            end
            if (push && !pop) begin
                count_n = count + 1'b1;
            end else if (pop && !push) begin
                count_n = count - 1'b1;
            end
        end
        // Registered flag, so it is computed from the post-edge state.
        prog_end_n = !pc_n_in_range && (count_n == '0) && (state_n == GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < fifo_depth; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pc       <= '0;
            prog_end <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= i_rdata;
                fifo_addr[wr_ptr] <= pc;
            end
            if (jump_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count    <= count_n;
            pc       <= pc_n;
            prog_end <= prog_end_n;
        end
    end

    assign inst_valid = (count != '0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_addr  = fifo_addr[rd_ptr];

endmodule
